// File: rtl/unidade_controle.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | unidade_controle: multi-cycle RV64 subset control unit (add/sub/addi/  |
// | ld/sd) that sequences fetch, decode, execute and write-back.           |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module unidade_controle (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] saida_IR,
  output logic        we,
  output logic        we_ram,
  output logic        we_mi,
  output logic        load_PC,
  output logic        load_IR,
  output logic [63:0] PCres,
  output logic [4:0]  Ra,
  output logic [4:0]  Rb,
  output logic [4:0]  Rw,
  output logic [63:0] entrada_mux_add_sub,
  output logic        decisor0,
  output logic        decisor1,
  output logic        decisor2,
  output logic        somador_subtrator,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [7:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_F_PC, S_F_WAIT, S_F_IR, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d, illegal_q, illegal_d;

  logic [4:0]  ra_q, rb_q, rw_q;
  logic [63:0] imm_q;
  logic        d0_q, d1_q, d2_q, sub_q, ld_q, sd_q, wr_q;

  logic [4:0]  dec_ra, dec_rb, dec_rw;
  logic [63:0] dec_imm;
  logic        dec_d0, dec_d1, dec_d2, dec_sub, dec_ld, dec_sd, dec_wr, dec_legal;

  // Combinational decode of the IR currently presented by the datapath
  always_comb begin
    dec_ra = 5'd0; dec_rb = 5'd0; dec_rw = 5'd0; dec_imm = 64'd0;
    dec_d0 = 1'b0; dec_d1 = 1'b0; dec_d2 = 1'b0; dec_sub = 1'b0;
    dec_ld = 1'b0; dec_sd = 1'b0; dec_wr = 1'b0; dec_legal = 1'b0;
    case (saida_IR[6:0])
      7'b0110011: begin
        if (saida_IR[14:12] == 3'b000 &&
            (saida_IR[31:25] == 7'b0000000 || saida_IR[31:25] == 7'b0100000)) begin
          dec_legal = 1'b1;
          dec_ra = saida_IR[19:15]; dec_rb = saida_IR[24:20]; dec_rw = saida_IR[11:7];
          dec_d1 = 1'b1;
          dec_sub = saida_IR[30];
          dec_wr = 1'b1;
        end
      end
      7'b0010011: begin
        if (saida_IR[14:12] == 3'b000) begin
          dec_legal = 1'b1;
          dec_ra = saida_IR[19:15]; dec_rw = saida_IR[11:7];
          dec_imm = {{52{saida_IR[31]}}, saida_IR[31:20]};
          dec_d0 = 1'b1; dec_d1 = 1'b1;
          dec_wr = 1'b1;
        end
      end
      7'b0000011: begin
        if (saida_IR[14:12] == 3'b011) begin
          dec_legal = 1'b1;
          dec_ra = saida_IR[19:15]; dec_rw = saida_IR[11:7];
          dec_imm = {{52{saida_IR[31]}}, saida_IR[31:20]};
          dec_d0 = 1'b1; dec_d1 = 1'b1; dec_d2 = 1'b1;
          dec_ld = 1'b1; dec_wr = 1'b1;
        end
      end
      7'b0100011: begin
        if (saida_IR[14:12] == 3'b011) begin
          dec_legal = 1'b1;
          // store data comes out of port A, base address out of port B
          dec_ra = saida_IR[24:20]; dec_rb = saida_IR[19:15];
          dec_imm = {{52{saida_IR[31]}}, saida_IR[31:25], saida_IR[11:7]};
          dec_d0 = 1'b1;
          dec_sd = 1'b1;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_F_PC;
          pc_d      = 5'd0;
          halted_d  = 1'b0;
          illegal_d = 1'b0;
        end
      end
      S_F_PC:   state_d = S_F_WAIT;
      S_F_WAIT: state_d = S_F_IR;
      S_F_IR:   state_d = S_DECODE;
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end
      end
      S_EXEC, S_WB: begin
        if (state_q == S_EXEC && ld_q) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (pc_q == 5'd31) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_q + 5'd1;
            state_d = S_F_PC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= 5'd0;
      cnt_q     <= 8'd0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      ra_q <= 5'd0; rb_q <= 5'd0; rw_q <= 5'd0; imm_q <= 64'd0;
      d0_q <= 1'b0; d1_q <= 1'b0; d2_q <= 1'b0; sub_q <= 1'b0;
      ld_q <= 1'b0; sd_q <= 1'b0; wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) begin
        ra_q <= dec_ra; rb_q <= dec_rb; rw_q <= dec_rw; imm_q <= dec_imm;
        d0_q <= dec_d0; d1_q <= dec_d1; d2_q <= dec_d2; sub_q <= dec_sub;
        ld_q <= dec_ld; sd_q <= dec_sd;
        wr_q <= dec_wr && (dec_rw != 5'd0);
      end
    end
  end

  always_comb begin
    we = 1'b0; we_ram = 1'b0; we_mi = 1'b0; load_PC = 1'b0; load_IR = 1'b0;
    PCres = 64'd0;
    Ra = 5'd0; Rb = 5'd0; Rw = 5'd0; entrada_mux_add_sub = 64'd0;
    decisor0 = 1'b0; decisor1 = 1'b0; decisor2 = 1'b0; somador_subtrator = 1'b0;
    busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = halted_q;
    illegal     = illegal_q;
    instr_count = cnt_q;
    case (state_q)
      S_F_PC: begin
        load_PC = 1'b1;
        PCres   = {59'd0, pc_q};
      end
      S_F_IR: load_IR = 1'b1;
      S_DECODE: begin
        if (dec_legal) begin
          Ra = dec_ra; Rb = dec_rb; Rw = dec_rw; entrada_mux_add_sub = dec_imm;
          decisor0 = dec_d0; decisor1 = dec_d1; decisor2 = dec_d2;
          somador_subtrator = dec_sub;
        end
      end
      S_EXEC, S_WB: begin
        Ra = ra_q; Rb = rb_q; Rw = rw_q; entrada_mux_add_sub = imm_q;
        decisor0 = d0_q; decisor1 = d1_q; decisor2 = d2_q;
        somador_subtrator = sub_q;
        we     = wr_q && (ld_q == (state_q == S_WB));
        we_ram = sd_q && (state_q == S_EXEC);
      end
      default: we_mi = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_unidade_controle: directed self-checking bench for the control unit.|
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] saida_IR = 32'd0;
  logic        we, we_ram, we_mi, load_PC, load_IR;
  logic [63:0] PCres, entrada_mux_add_sub;
  logic [4:0]  Ra, Rb, Rw;
  logic        decisor0, decisor1, decisor2, somador_subtrator;
  logic        busy, halted, illegal;
  logic [7:0]  instr_count;

  int checks = 0;
  int errors = 0;

  unidade_controle dut (
    .clk(clk), .reset(reset), .start(start), .saida_IR(saida_IR),
    .we(we), .we_ram(we_ram), .we_mi(we_mi), .load_PC(load_PC), .load_IR(load_IR),
    .PCres(PCres), .Ra(Ra), .Rb(Rb), .Rw(Rw),
    .entrada_mux_add_sub(entrada_mux_add_sub),
    .decisor0(decisor0), .decisor1(decisor1), .decisor2(decisor2),
    .somador_subtrator(somador_subtrator),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Strobes must stay mutually exclusive in every cycle
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert ($onehot0({we, we_ram, load_PC, load_IR})) else begin
        errors++;
        $error("FAIL strobe_onehot observed=%0b expected=onehot0", {we, we_ram, load_PC, load_IR});
      end
    end
  end

  initial begin
    repeat (2) tick();
    chk("rst_strobes", {59'd0, we, we_ram, we_mi, load_PC, load_IR}, 64'd0);
    chk("rst_pcres", PCres, 64'd0);
    chk("rst_regs", {49'd0, Ra, Rb, Rw}, 64'd0);
    chk("rst_flags", {53'd0, busy, halted, illegal, instr_count}, 64'd0);
    reset = 1'b0;
    tick();

    // add x6,x2,x4
    saida_IR = 32'h00410333;
    pulse_start();
    chk("add_fpc", {62'd0, load_PC, busy}, 64'd3);
    chk("add_pcres0", PCres, 64'd0);
    tick();
    chk("add_fwait", {60'd0, we, we_ram, load_PC, load_IR}, 64'd0);
    tick();
    chk("add_fir", {63'd0, load_IR}, 64'd1);
    tick();
    chk("add_dec_regs", {49'd0, Ra, Rb, Rw}, {49'd0, 5'd2, 5'd4, 5'd6});
    chk("add_dec_sel", {60'd0, decisor0, decisor1, decisor2, somador_subtrator}, 64'b0100);
    chk("add_dec_we", {63'd0, we}, 64'd0);
    tick();
    chk("add_exec_we", {63'd0, we}, 64'd1);
    tick();
    chk("add_next_pc", {62'd0, we, load_PC}, 64'd1);
    chk("add_pcres1", PCres, 64'd1);
    chk("add_count", {56'd0, instr_count}, 64'd1);

    // sub x7,x6,x3
    saida_IR = 32'h403303B3;
    repeat (3) tick();
    chk("sub_dec_regs", {49'd0, Ra, Rb, Rw}, {49'd0, 5'd6, 5'd3, 5'd7});
    chk("sub_dec_sub", {63'd0, somador_subtrator}, 64'd1);
    tick();
    chk("sub_exec_we", {62'd0, we, somador_subtrator}, 64'd3);
    tick();
    chk("sub_count", {56'd0, instr_count}, 64'd2);
    chk("sub_pcres2", PCres, 64'd2);

    // ld x2,8(x0)
    saida_IR = 32'h00803103;
    repeat (3) tick();
    chk("ld_imm", entrada_mux_add_sub, 64'd8);
    chk("ld_sel", {61'd0, decisor0, decisor1, decisor2}, 64'b111);
    tick();
    chk("ld_exec_we", {62'd0, we, busy}, 64'd1);
    tick();
    chk("ld_wb_we", {63'd0, we}, 64'd1);
    chk("ld_wb_rw", {59'd0, Rw}, 64'd2);
    tick();
    chk("ld_retire", {56'd0, instr_count}, 64'd3);
    chk("ld_pcres3", PCres, 64'd3);

    // sd x7,16(x2), then an asynchronous reset in the middle of EXEC
    saida_IR = 32'h00713823;
    repeat (3) tick();
    chk("sd_regs", {54'd0, Ra, Rb}, {54'd0, 5'd7, 5'd2});
    chk("sd_imm", entrada_mux_add_sub, 64'd16);
    chk("sd_sel", {61'd0, decisor0, decisor1, decisor2}, 64'b100);
    tick();
    chk("sd_exec", {62'd0, we_ram, we}, 64'b10);
    #1 reset = 1'b1;
    #1;
    chk("arst_strobes", {59'd0, we, we_ram, we_mi, load_PC, load_IR}, 64'd0);
    chk("arst_busy_flags", {53'd0, busy, halted, illegal, instr_count}, 64'd0);
    chk("arst_data", {61'd0, decisor0, decisor1, decisor2} | entrada_mux_add_sub | {49'd0, Ra, Rb, Rw}, 64'd0);
    #1 reset = 1'b0;
    tick();

    // addi x1,x2,-1 followed by an illegal all-zero word
    saida_IR = 32'hFFF10093;
    pulse_start();
    chk("addi_pcres0", PCres, 64'd0);
    repeat (3) tick();
    chk("addi_imm", entrada_mux_add_sub, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_sel", {54'd0, Ra, Rw}, {54'd0, 5'd2, 5'd1});
    tick();
    chk("addi_we", {63'd0, we}, 64'd1);
    tick();
    chk("addi_count", {56'd0, instr_count}, 64'd1);
    saida_IR = 32'h00000000;
    repeat (3) tick();
    chk("ill_dec_strobes", {62'd0, we, we_ram}, 64'd0);
    tick();
    chk("ill_halt", {61'd0, busy, halted, illegal}, 64'b011);
    chk("ill_count", {56'd0, instr_count}, 64'd1);
    tick();
    chk("ill_hold", {59'd0, we, we_ram, load_PC, load_IR, busy}, 64'd0);

    // addi x0,x0,1 across all 32 slots: we suppressed, halts at pc 31
    saida_IR = 32'h00100013;
    pulse_start();
    chk("prog_restart", {62'd0, halted, illegal}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      chk("prog_pcres", PCres, 64'(i));
      tick();
      if (i == 5) start = 1'b1;
      tick();
      start = 1'b0;
      repeat (2) tick();
      chk("prog_we_rd0", {62'd0, we, busy}, 64'd1);
      tick();
    end
    chk("prog_halt", {61'd0, busy, halted, illegal}, 64'b010);
    chk("prog_count", {56'd0, instr_count}, 64'd33);

    saida_IR = 32'h00410333;
    pulse_start();
    chk("restart_pcres", PCres, 64'd0);
    chk("restart_flags", {61'd0, load_PC, busy, halted}, 64'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
